// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: stage indices,
// controller states and the fixed stall/bubble patterns.
package pipe_pkg;

  localparam int NUM_STG = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef logic [NUM_STG-1:0] stg_vec_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // A stalling stage holds itself and everything upstream; the stage just
  // downstream receives a bubble so the older instructions keep draining.
  localparam stg_vec_t STALL_MEM  = 6'b011111;
  localparam stg_vec_t STALL_EX   = 6'b001111;
  localparam stg_vec_t STALL_ID   = 6'b000111;
  localparam stg_vec_t BUBBLE_MEM = 6'b100000;
  localparam stg_vec_t BUBBLE_EX  = 6'b010000;
  localparam stg_vec_t BUBBLE_ID  = 6'b001000;
  localparam stg_vec_t FLUSH_EXC  = 6'b011110;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/response bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             req_id;
  logic             req_ex;
  logic             req_mem;
  logic             exc_valid;
  logic [PC_W-1:0]  exc_vector;
  logic [5:0]       stall;
  logic [5:0]       flush;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             exc_busy;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output req_id, req_ex, req_mem, exc_valid, exc_vector,
    input  stall, flush, redirect_valid, redirect_pc, exc_busy,
           mem_timeout, stall_cnt
  );

  modport slave (
    input  req_id, req_ex, req_mem, exc_valid, exc_vector,
    output stall, flush, redirect_valid, redirect_pc, exc_busy,
           mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_wdog.sv
// MEM bus-wait watchdog: counts consecutive req_mem cycles and raises a sticky
// flag once the run length reaches TIMEOUT.
module pipe_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req_mem,
  output logic timeout
);

  logic [15:0] cnt_q;
  logic [16:0] cnt_inc;

  // Compare against the post-increment value so the flag rises on the same
  // edge at which the count reaches TIMEOUT.
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      if (!req_mem)
        cnt_q <= '0;
      else if (cnt_q != '1)
        cnt_q <= cnt_inc[15:0];

      if (req_mem && (cnt_inc >= 17'(TIMEOUT)))
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges ID/EX/MEM stall
// requests and sequences precise exception entry (drain, flush, redirect).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  state_t           state, state_nxt;
  logic [PC_W-1:0]  vec_q;
  logic [CNT_W-1:0] cnt_q;
  stg_vec_t         stall_d, flush_d;
  logic             redirect_d, busy_d;
  logic             exc_accept;

  // Only RUN can accept; later exceptions are dropped until the redirect.
  assign exc_accept = (state == ST_RUN) && bus.exc_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (exc_accept) state_nxt = bus.req_mem ? ST_DRAIN : ST_FLUSH;
      ST_DRAIN: if (!bus.req_mem) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted, so a request seen during
  // reset never reaches the pipeline.
  always_comb begin
    stall_d    = '0;
    flush_d    = '0;
    redirect_d = 1'b0;
    busy_d     = 1'b0;
    if (rst) begin
      unique case (state)
        ST_RUN: begin
          if (bus.req_mem) begin
            stall_d = STALL_MEM;
            flush_d = BUBBLE_MEM;
          end else if (bus.req_ex) begin
            stall_d = STALL_EX;
            flush_d = BUBBLE_EX;
          end else if (bus.req_id) begin
            stall_d = STALL_ID;
            flush_d = BUBBLE_ID;
          end
        end
        ST_DRAIN: begin
          busy_d = 1'b1;
          if (bus.req_mem) begin
            stall_d = STALL_MEM;
            flush_d = BUBBLE_MEM;
          end
        end
        ST_FLUSH: begin
          busy_d     = 1'b1;
          redirect_d = 1'b1;
          flush_d    = FLUSH_EXC;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            vec_q <= '0;
    else if (exc_accept) vec_q <= bus.exc_vector;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else if (stall_d[STG_PC] && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  pipe_wdog #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .req_mem (bus.req_mem),
    .timeout (bus.mem_timeout)
  );

  assign bus.stall          = stall_d;
  assign bus.flush          = flush_d;
  assign bus.redirect_valid = redirect_d;
  assign bus.redirect_pc    = vec_q;
  assign bus.exc_busy       = busy_d;
  assign bus.stall_cnt      = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.PC_W(32), .CNT_W(32)) bus  ();
  pipe_hazard_ctrl_if #(.PC_W(32), .CNT_W(3))  bus3 ();

  pipe_hazard_ctrl #(.PC_W(32), .CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  pipe_hazard_ctrl #(.PC_W(32), .CNT_W(3), .MEM_TIMEOUT(255)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  // Model: exception progress as two flags, plain integer counters.
  bit          m_drain, m_flush, m_to;
  logic [31:0] m_vec;
  int          m_wd;
  longint      m_cnt, m_cnt3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_drain = 0; m_flush = 0; m_to = 0;
    m_vec = '0; m_wd = 0; m_cnt = 0; m_cnt3 = 0;
  endtask

  task automatic drive(input bit id, ex, mem, ev, input logic [31:0] vec);
    bus.req_id  = id;  bus.req_ex  = ex;  bus.req_mem  = mem;
    bus.exc_valid  = ev;  bus.exc_vector  = vec;
    bus3.req_id = id;  bus3.req_ex = ex;  bus3.req_mem = mem;
    bus3.exc_valid = ev;  bus3.exc_vector = vec;
  endtask

  // One clock cycle: drive, check this cycle's outputs, advance the model.
  task automatic step(input bit id, ex, mem, ev, input logic [31:0] vec);
    logic [5:0] es, ef;
    bit         erv, eb;
    @(negedge clk);
    drive(id, ex, mem, ev, vec);
    #2;
    es = '0; ef = '0; erv = 0; eb = 0;
    if (m_flush) begin
      ef = 6'b011110; erv = 1; eb = 1;
    end else if (m_drain) begin
      eb = 1;
      if (mem) begin es = 6'b011111; ef = 6'b100000; end
    end else if (mem) begin
      es = 6'b011111; ef = 6'b100000;
    end else if (ex) begin
      es = 6'b001111; ef = 6'b010000;
    end else if (id) begin
      es = 6'b000111; ef = 6'b001000;
    end

    check("stall",          64'(bus.stall),          64'(es));
    check("flush",          64'(bus.flush),          64'(ef));
    check("redirect_valid", 64'(bus.redirect_valid), 64'(erv));
    check("exc_busy",       64'(bus.exc_busy),       64'(eb));
    check("redirect_pc",    64'(bus.redirect_pc),    64'(m_vec));
    check("mem_timeout",    64'(bus.mem_timeout),    64'(m_to));
    check("stall_cnt",      64'(bus.stall_cnt),      64'(m_cnt));
    check("stall3",         64'(bus3.stall),         64'(es));
    check("stall_cnt3",     64'(bus3.stall_cnt),     64'(m_cnt3));

    if (m_flush) m_flush = 0;
    else if (m_drain) begin
      if (!mem) begin m_drain = 0; m_flush = 1; end
    end else if (ev) begin
      m_vec = vec;
      if (mem) m_drain = 1; else m_flush = 1;
    end
    if (mem) m_wd = (m_wd < 65535) ? m_wd + 1 : m_wd;
    else     m_wd = 0;
    if (m_wd >= TO) m_to = 1;
    if (es[0]) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt3 < 7) m_cnt3++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state and priority decode.
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    check("stall_cnt_after_prio", 64'(bus.stall_cnt), 64'd2);

    // Exception accepted in RUN without a memory wait.
    step(0, 0, 0, 1, 32'h8000_0180);
    step(0, 0, 0, 0, '0);
    check("run_exc_redirect", 64'(bus.redirect_valid), 64'd1);
    check("run_exc_pc",       64'(bus.redirect_pc),    64'h8000_0180);
    check("run_exc_flush",    64'(bus.flush),          64'b011110);
    step(0, 0, 0, 0, '0);
    check("run_exc_busy_drop", 64'(bus.exc_busy), 64'd0);

    // Exception during a memory wait; second exception must be dropped.
    step(0, 0, 1, 1, 32'hBFC0_0380);
    step(1, 1, 1, 1, 32'hDEAD_BEEF);
    step(0, 1, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    step(1, 1, 0, 0, '0);
    step(1, 1, 1, 0, '0);
    check("drain_exc_pc", 64'(bus.redirect_pc), 64'hBFC0_0380);
    step(0, 0, 0, 0, '0);

    // Asynchronous reset mid-cycle with a request pending.
    step(0, 1, 0, 0, '0);
    @(negedge clk);
    drive(0, 1, 0, 0, '0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_stall",       64'(bus.stall),          64'd0);
    check("rst_flush",       64'(bus.flush),          64'd0);
    check("rst_busy",        64'(bus.exc_busy),       64'd0);
    check("rst_redirect",    64'(bus.redirect_valid), 64'd0);
    check("rst_pc",          64'(bus.redirect_pc),    64'd0);
    check("rst_cnt",         64'(bus.stall_cnt),      64'd0);
    check("rst_timeout",     64'(bus.mem_timeout),    64'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, '0);
    rst = 1'b1;
    step(0, 0, 0, 0, '0);

    // Exception whose drain is cut short by reset: no redirect afterwards.
    step(0, 0, 1, 1, 32'h1234_5678);
    do_reset();
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // Watchdog: six consecutive memory-wait cycles, then release.
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    check("wdog_sticky", 64'(bus.mem_timeout), 64'd1);

    // Stall counter saturation on the narrow instance.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    check("cnt3_saturated", 64'(bus3.stall_cnt), 64'd7);
    check("cnt32_ten",      64'(bus.stall_cnt),  64'd10);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
           $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequenced stall/flush controller for the 5-stage MIPS pipeline.
- Merges stall requests from ID (load-use), EX (multi-cycle mul/div) and MEM (bus wait) into per-stage stall and bubble vectors.
- Sequences precise exception entry: waits for an in-flight memory access to drain, flushes the pipeline registers, then redirects PC.
- Also keeps a saturating stall-cycle counter and a MEM-wait watchdog.

Parameters:
- PC_W, 32, width of the exception vector and redirect PC.
- CNT_W, 32, width of the stall-cycle counter.
- MEM_TIMEOUT, 255, consecutive req_mem cycles before the watchdog fires. Legal range is 1 to 2^16-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_id  in  1  stall request from ID (load-use hazard).
- req_ex  in  1  stall request from EX (mul/div busy).
- req_mem  in  1  stall request from MEM (bus not acknowledged).
- exc_valid  in  1  exception raised, single-cycle pulse, from MEM.
- exc_vector  in  PC_W  handler address, valid with exc_valid.
- stall  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb. 1 means hold the register.
- flush  out  6  same indexing. 1 means load a bubble (nop) into that stage's input register.
- redirect_valid  out  1  one-cycle pulse: PC loads redirect_pc.
- redirect_pc  out  PC_W  redirect target.
- exc_busy  out  1  high from exception accept until the redirect cycle, inclusive.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  count of cycles with stall[0]=1. Saturates at all-ones.

Behaviour:
- Reset (rst=0, async): state=RUN, all outputs 0, watchdog counter 0, captured vector 0.
- State machine states are RUN, DRAIN and FLUSH.

RUN, stall/flush decode (combinational, same cycle as the requests), highest priority first:
- req_mem: stall=6'b011111, flush=6'b100000.
- else req_ex: stall=6'b001111, flush=6'b010000.
- else req_id: stall=6'b000111, flush=6'b001000.
- else: stall=0, flush=0.

RUN, exception accept:
- exc_valid=1 latches exc_vector and sets exc_busy=1 from the next cycle.
- If req_mem=1 in that cycle: next state DRAIN.
- Otherwise: next state FLUSH.
- exc_valid while exc_busy=1 is ignored. The first exception wins.

DRAIN:
- stall=6'b011111, flush=6'b100000, for as long as req_mem=1.
- Exits to FLUSH in the cycle after req_mem is sampled 0.
- req_id and req_ex are ignored in this state.

FLUSH (exactly one cycle):
- stall=0, flush=6'b011110.
- redirect_valid=1, redirect_pc = captured vector.
- Next state RUN. exc_busy drops after this cycle.
- Requests present during FLUSH are ignored. The flushed instructions are discarded.

Watchdog:
- Counter increments each cycle req_mem=1 and clears when req_mem=0.
- When the counter reaches MEM_TIMEOUT, mem_timeout is set. It stays set until reset.
- Stall behaviour is unaffected by the watchdog.

stall_cnt:
- Registered; increments on each cycle where stall[0]=1.
- Holds at 2^CNT_W-1.

Reset mid-operation:
- Aborts DRAIN/FLUSH immediately.
- No redirect_valid is issued for the aborted exception.

Decomposition:
- Shared package pipe_pkg:
  - stage index constants STG_PC..STG_WB (0..5);
  - state encoding ST_RUN, ST_DRAIN, ST_FLUSH;
  - the constant vectors STALL_MEM/EX/ID and BUBBLE_MEM/EX/ID, FLUSH_EXC.
- One natural sub-module: pipe_wdog, the req_mem timeout counter with its sticky flag.
- The stall/flush priority decode stays inline.

Test Plan:
- Reset behaviour: rst=0 asserted mid-run with req_ex=1 -> all outputs 0 immediately. After release with no requests -> stall=0, flush=0, stall_cnt=0.
- Priority: req_id=1 for 1 cycle -> stall=000111, flush=001000. Then req_id=req_ex=req_mem=1 together -> stall=011111, flush=100000. stall_cnt=2 afterwards.
- Exception in RUN: exc_valid=1 with exc_vector=32'h80000180 and req_mem=0 -> next cycle flush=011110, redirect_valid=1, redirect_pc=32'h80000180, exc_busy=1. Following cycle: RUN, exc_busy=0.
- Exception during memory wait: exc_valid=1 with req_mem=1, and req_mem held 3 more cycles -> DRAIN with stall=011111 for those cycles, then FLUSH and redirect one cycle after req_mem drops. A second exc_valid during DRAIN is ignored (redirect_pc keeps the first vector).
- Watchdog: MEM_TIMEOUT=4, req_mem held 6 cycles -> mem_timeout rises when the count reaches 4 and stays 1 after req_mem=0.
- Saturation: CNT_W=3 with stall forced for 10 cycles -> stall_cnt reaches 7 and holds at 7.
